// File: rtl/sfp_tx_arbiter.sv
// sfp_tx_arbiter: round-robin share of the 32-bit SFP transmit payload path
// between four source channels. Each grant emits a header word followed by up
// to MAX_BURST data words. Packets longer than that are split and resume on a
// later grant flagged as a continuation.
module sfp_tx_arbiter #(
    parameter int unsigned MAX_BURST  = 256,
    parameter int unsigned GAP_CYCLES = 4,
    parameter logic [7:0]  HDR_TAG    = 8'hA5
) (
    input  logic         clk_in,
    input  logic         rst_n,
    input  logic         arb_en,
    input  logic [3:0]   req_valid,
    input  logic [127:0] req_data,
    input  logic [3:0]   req_last,
    output logic [3:0]   req_ready,
    output logic         out_valid,
    output logic [31:0]  out_data,
    output logic         out_sop,
    output logic         out_eop,
    input  logic         out_ready,
    output logic [1:0]   grant_ch,
    output logic         busy,
    output logic         trunc_pulse
);

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned CH_W   = 2;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BEAT_W = 10;
    localparam int unsigned GAP_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    state_t              state;
    logic [CH_W-1:0]     last_grant;
    logic [NUM_CH-1:0]   cont;
    logic [BEAT_W-1:0]   beat_cnt;
    logic [GAP_W-1:0]    gap_cnt;

    logic                out_free;
    logic                any_req;
    logic [CH_W-1:0]     next_grant;
    logic                sel_valid;
    logic                sel_last;
    logic [DATA_W-1:0]   sel_data;
    logic                xfer;
    logic                burst_full;
    logic                gap_done;
    logic [DATA_W-1:0]   hdr_word;

    // Output register may take a new word when empty or being drained this cycle
    assign out_free   = !out_valid || out_ready;

    // Granted channel's request signals
    assign sel_valid  = req_valid[grant_ch];
    assign sel_last   = req_last[grant_ch];
    assign sel_data   = req_data[{grant_ch, 5'b0} +: DATA_W];

    // Only the granted channel is accepted, and only while the output can load
    assign req_ready  = (state == ST_DATA && out_free) ? (4'b0001 << grant_ch) : 4'b0000;
    assign xfer       = (state == ST_DATA) && out_free && sel_valid;

    // Current beat is the last one the burst is allowed to carry
    assign burst_full = (beat_cnt == BEAT_W'(MAX_BURST - 1));

    // Gap counter reaches its final idle cycle after eop acceptance
    assign gap_done   = ((32'(gap_cnt) + 32'd1) >= GAP_CYCLES);

    assign hdr_word   = {HDR_TAG, 7'd0, cont[grant_ch], 14'd0, grant_ch};

    // Round-robin search starting one past the previous grant; offset 1 wins ties
    always_comb begin
        next_grant = last_grant;
        any_req    = 1'b0;
        for (int i = NUM_CH; i >= 1; i--) begin
            if (req_valid[last_grant + CH_W'(i)]) begin
                any_req    = 1'b1;
                next_grant = last_grant + CH_W'(i);
            end
        end
    end

    // Arbitration FSM with registered output stage
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            last_grant  <= 2'd3;
            grant_ch    <= 2'd0;
            cont        <= '0;
            beat_cnt    <= '0;
            gap_cnt     <= '0;
            busy        <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_sop     <= 1'b0;
            out_eop     <= 1'b0;
            trunc_pulse <= 1'b0;
        end else begin
            trunc_pulse <= 1'b0;
            if (out_free) begin
                out_valid <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (arb_en && any_req) begin
                        grant_ch   <= next_grant;
                        last_grant <= next_grant;
                        busy       <= 1'b1;
                        state      <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (out_free) begin
                        out_valid <= 1'b1;
                        out_data  <= hdr_word;
                        out_sop   <= 1'b1;
                        out_eop   <= 1'b0;
                        beat_cnt  <= '0;
                        state     <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (xfer) begin
                        out_valid <= 1'b1;
                        out_data  <= sel_data;
                        out_sop   <= 1'b0;
                        beat_cnt  <= beat_cnt + BEAT_W'(1);
                        if (sel_last) begin
                            out_eop        <= 1'b1;
                            cont[grant_ch] <= 1'b0;
                            gap_cnt        <= '0;
                            state          <= ST_GAP;
                        end else if (burst_full) begin
                            out_eop        <= 1'b1;
                            cont[grant_ch] <= 1'b1;
                            trunc_pulse    <= 1'b1;
                            gap_cnt        <= '0;
                            state          <= ST_GAP;
                        end else begin
                            out_eop <= 1'b0;
                        end
                    end
                end
                ST_GAP: begin
                    // Eop word still pending: nothing else loads, so out_valid tracks it
                    if (out_valid) begin
                        gap_cnt <= '0;
                        if (out_ready && GAP_CYCLES == 0) begin
                            busy  <= 1'b0;
                            state <= ST_IDLE;
                        end
                    end else if (gap_done) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sfp_tx_arbiter.sv
// Self-checking bench for sfp_tx_arbiter: packet queues per channel feed the
// DUT, and a packet-level round-robin model predicts the framed output stream.
module tb_sfp_tx_arbiter;

    localparam int         MAX_BURST  = 256;
    localparam int         GAP_CYCLES = 4;
    localparam logic [7:0] HDR_TAG    = 8'hA5;

    logic         clk_in = 1'b0;
    logic         rst_n;
    logic         arb_en;
    logic [3:0]   req_valid;
    logic [127:0] req_data;
    logic [3:0]   req_last;
    logic [3:0]   req_ready;
    logic         out_valid;
    logic [31:0]  out_data;
    logic         out_sop;
    logic         out_eop;
    logic         out_ready;
    logic [1:0]   grant_ch;
    logic         busy;
    logic         trunc_pulse;

    sfp_tx_arbiter #(
        .MAX_BURST  (MAX_BURST),
        .GAP_CYCLES (GAP_CYCLES),
        .HDR_TAG    (HDR_TAG)
    ) dut (
        .clk_in      (clk_in),
        .rst_n       (rst_n),
        .arb_en      (arb_en),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_sop     (out_sop),
        .out_eop     (out_eop),
        .out_ready   (out_ready),
        .grant_ch    (grant_ch),
        .busy        (busy),
        .trunc_pulse (trunc_pulse)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Stimulus: per-channel word streams {last, data}
    logic [32:0] drv_q[4][$];
    // Model: per-channel words and remaining packet lengths
    logic [31:0] m_words[4][$];
    int          m_len[4][$];
    logic [3:0]  m_cont;
    int          m_rr;
    // Expected accepted output words {sop, eop, data}
    logic [33:0] exp_q[$];
    int          trunc_exp;
    int          trunc_seen;

    // Observation logs
    logic [31:0] hdr_log[$];
    int          len_log[$];
    int          cur_len;
    int          last_eop_cyc;
    bit          have_eop;
    bit          gap_chk;
    bit          rnd_ready;
    bit          bubble_en;
    bit          arb_en_cmd;
    bit          prev_stall;
    logic [33:0] prev_word;
    logic        s_busy;
    logic        s_valid;
    logic        s_sop;
    logic        s_eop;
    logic [1:0]  s_grant;

    task automatic clear_tb_state();
        for (int c = 0; c < 4; c++) begin
            drv_q[c].delete();
            m_words[c].delete();
            m_len[c].delete();
        end
        exp_q.delete();
        hdr_log.delete();
        len_log.delete();
        m_cont     = 4'b0;
        m_rr       = 3;
        trunc_exp  = 0;
        trunc_seen = 0;
        cur_len    = 0;
        have_eop   = 1'b0;
        prev_stall = 1'b0;
    endtask

    task automatic clear_logs();
        hdr_log.delete();
        len_log.delete();
        trunc_exp  = 0;
        trunc_seen = 0;
        have_eop   = 1'b0;
    endtask

    task automatic add_packet(input int c, input int len);
        logic [31:0] w;
        for (int i = 0; i < len; i++) begin
            w = $urandom;
            drv_q[c].push_back({(i == len - 1), w});
            m_words[c].push_back(w);
        end
        m_len[c].push_back(len);
    endtask

    // Packet-level round robin: every loaded channel requests continuously
    task automatic model_build();
        int  c;
        int  n;
        bit  found;
        while (1) begin
            found = 1'b0;
            c     = 0;
            for (int i = 1; i <= 4; i++) begin
                if (!found && m_len[(m_rr + i) % 4].size() > 0) begin
                    found = 1'b1;
                    c     = (m_rr + i) % 4;
                end
            end
            if (!found) break;
            m_rr = c;
            exp_q.push_back({1'b1, 1'b0, HDR_TAG, 7'd0, m_cont[c], 14'd0, 2'(c)});
            n = (m_len[c][0] > MAX_BURST) ? MAX_BURST : m_len[c][0];
            for (int i = 0; i < n; i++) begin
                exp_q.push_back({1'b0, (i == n - 1), m_words[c].pop_front()});
            end
            if (m_len[c][0] > MAX_BURST) begin
                m_len[c][0] = m_len[c][0] - MAX_BURST;
                m_cont[c]   = 1'b1;
                trunc_exp++;
            end else begin
                void'(m_len[c].pop_front());
                m_cont[c] = 1'b0;
            end
        end
    endtask

    // One clock: drive at negedge, observe 1 time unit later, retire on posedge
    task automatic step();
        logic [3:0]  fire;
        logic [33:0] exp_w;
        logic [33:0] cur_w;
        @(negedge clk_in);
        arb_en    = arb_en_cmd;
        out_ready = rnd_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (drv_q[c].size() > 0 && (!bubble_en || $urandom_range(0, 3) != 0)) begin
                req_valid[c]          = 1'b1;
                req_data[32*c +: 32]  = drv_q[c][0][31:0];
                req_last[c]           = drv_q[c][0][32];
            end else begin
                req_valid[c]          = 1'b0;
                req_data[32*c +: 32]  = $urandom;
                req_last[c]           = 1'($urandom_range(0, 1));
            end
        end
        #1;
        cyc++;
        s_busy  = busy;
        s_valid = out_valid;
        s_sop   = out_sop;
        s_eop   = out_eop;
        s_grant = grant_ch;
        fire    = req_valid & req_ready;
        cur_w   = {out_sop, out_eop, out_data};

        if (prev_stall) begin
            checks++;
            if (!out_valid || cur_w !== prev_word) begin
                errors++;
                $display("FAIL stall_hold: got valid=%0b word=%h required valid=1 word=%h", out_valid, cur_w, prev_word);
            end
        end
        if (out_valid && !out_ready) begin
            checks++;
            if (req_ready !== 4'b0000) begin
                errors++;
                $display("FAIL ready_while_stalled: got req_ready=%b required 0000", req_ready);
            end
        end
        if (trunc_pulse) begin
            trunc_seen++;
            checks++;
            if (!(out_valid && out_eop)) begin
                errors++;
                $display("FAIL trunc_align: got valid=%0b eop=%0b required 1/1", out_valid, out_eop);
            end
        end
        if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL out_word: got unexpected word %h required none", cur_w);
            end else begin
                exp_w = exp_q.pop_front();
                if (cur_w !== exp_w) begin
                    errors++;
                    $display("FAIL out_word: got %h required %h", cur_w, exp_w);
                end
                if (exp_w[33]) begin
                    checks++;
                    if (grant_ch !== exp_w[1:0]) begin
                        errors++;
                        $display("FAIL grant_ch: got %0d required %0d", grant_ch, exp_w[1:0]);
                    end
                end
            end
            if (out_sop) begin
                hdr_log.push_back(out_data);
                cur_len = 0;
                if (gap_chk && have_eop) begin
                    checks++;
                    if (cyc - last_eop_cyc != GAP_CYCLES + 3) begin
                        errors++;
                        $display("FAIL eop_to_header: got %0d cycles required %0d", cyc - last_eop_cyc, GAP_CYCLES + 3);
                    end
                end
            end else begin
                cur_len++;
                if (out_eop) begin
                    len_log.push_back(cur_len);
                    last_eop_cyc = cyc;
                    have_eop     = 1'b1;
                end
            end
        end
        prev_stall = out_valid && !out_ready;
        prev_word  = cur_w;
        @(posedge clk_in);
        for (int c = 0; c < 4; c++) begin
            if (fire[c]) void'(drv_q[c].pop_front());
        end
    endtask

    task automatic drain(input int budget, input string name);
        bit done;
        done = 1'b0;
        for (int n = 0; n < budget && !done; n++) begin
            step();
            done = (exp_q.size() == 0) && !s_busy && drv_q[0].size() == 0 &&
                   drv_q[1].size() == 0 && drv_q[2].size() == 0 && drv_q[3].size() == 0;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s drain: got %0d words pending required 0", name, exp_q.size());
        end
    endtask

    task automatic apply_reset();
        @(negedge clk_in);
        rst_n     = 1'b0;
        req_valid = 4'b0;
        req_last  = 4'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk_in);
        rst_n = 1'b1;
        clear_tb_state();
    endtask

    task automatic test_reset();
        rst_n     = 1'b1;
        arb_en    = 1'b1;
        req_valid = 4'hF;
        req_last  = 4'h0;
        req_data  = '0;
        out_ready = 1'b1;
        #3 rst_n = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        checks++;
        if ({out_valid, out_sop, out_eop, trunc_pulse, busy, grant_ch, req_ready, out_data} !== 42'd0) begin
            errors++;
            $display("FAIL reset_values: got v=%0b sop=%0b eop=%0b tr=%0b busy=%0b g=%0d rdy=%b d=%h required all 0",
                     out_valid, out_sop, out_eop, trunc_pulse, busy, grant_ch, req_ready, out_data);
        end
        @(negedge clk_in);
        rst_n     = 1'b1;
        req_valid = 4'h0;
        clear_tb_state();
    endtask

    task automatic test_single();
        int n0, n_busy, n_hdr, n_eop, n_idle;
        logic [1:0] g_at_busy;
        n_busy = -1; n_hdr = -1; n_eop = -1; n_idle = -1;
        g_at_busy = 2'd3;
        repeat (3) step();
        add_packet(0, 3);
        model_build();
        step();
        n0 = cyc;
        checks++;
        if (s_busy !== 1'b0) begin
            errors++;
            $display("FAIL single_idle_busy: got %0b required 0", s_busy);
        end
        for (int i = 0; i < 40 && n_idle < 0; i++) begin
            step();
            if (n_busy < 0 && s_busy) begin n_busy = cyc; g_at_busy = s_grant; end
            if (n_hdr < 0 && s_valid && s_sop) n_hdr = cyc;
            if (n_eop < 0 && s_valid && s_eop) n_eop = cyc;
            if (n_eop >= 0 && cyc > n_eop && !s_busy) n_idle = cyc;
        end
        checks++;
        if (n_busy != n0 + 1 || g_at_busy !== 2'd0) begin
            errors++;
            $display("FAIL single_grant_latency: got cycle %0d grant %0d required %0d grant 0", n_busy - n0, g_at_busy, 1);
        end
        checks++;
        if (n_hdr != n0 + 2) begin
            errors++;
            $display("FAIL single_header_latency: got %0d required 2", n_hdr - n0);
        end
        checks++;
        if (n_eop != n_hdr + 3) begin
            errors++;
            $display("FAIL single_eop_position: got %0d required 3", n_eop - n_hdr);
        end
        checks++;
        if (n_idle != n_eop + GAP_CYCLES + 1) begin
            errors++;
            $display("FAIL single_busy_drop: got %0d required %0d", n_idle - n_eop, GAP_CYCLES + 1);
        end
        checks++;
        if (hdr_log.size() != 1 || hdr_log[0] !== 32'hA500_0000) begin
            errors++;
            $display("FAIL single_header: got %0d headers first=%h required 1 A5000000", hdr_log.size(),
                     (hdr_log.size() > 0) ? hdr_log[0] : 32'h0);
        end
        drain(50, "single");
    endtask

    task automatic test_round_robin();
        int exp_ord[5] = '{0, 1, 2, 3, 0};
        apply_reset();
        add_packet(0, 2);
        add_packet(0, 2);
        for (int c = 1; c < 4; c++) add_packet(c, 2);
        model_build();
        gap_chk = 1'b1;
        drain(300, "round_robin");
        gap_chk = 1'b0;
        checks++;
        if (hdr_log.size() != 5) begin
            errors++;
            $display("FAIL rr_header_count: got %0d required 5", hdr_log.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (int'(hdr_log[i][1:0]) != exp_ord[i]) begin
                    errors++;
                    $display("FAIL rr_order[%0d]: got %0d required %0d", i, hdr_log[i][1:0], exp_ord[i]);
                end
            end
        end
    endtask

    task automatic test_truncation();
        logic [31:0] exp_hdr[3] = '{32'hA500_0002, 32'hA501_0002, 32'hA500_0002};
        int          exp_len[3] = '{256, 44, 256};
        clear_logs();
        add_packet(2, 300);
        add_packet(2, 256);
        model_build();
        drain(2000, "truncation");
        checks++;
        if (hdr_log.size() != 3 || len_log.size() != 3) begin
            errors++;
            $display("FAIL trunc_bursts: got %0d headers %0d bursts required 3 3", hdr_log.size(), len_log.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (hdr_log[i] !== exp_hdr[i] || len_log[i] != exp_len[i]) begin
                    errors++;
                    $display("FAIL trunc_burst[%0d]: got hdr=%h len=%0d required hdr=%h len=%0d",
                             i, hdr_log[i], len_log[i], exp_hdr[i], exp_len[i]);
                end
            end
        end
        checks++;
        if (trunc_seen != 1) begin
            errors++;
            $display("FAIL trunc_pulse_count: got %0d required 1", trunc_seen);
        end
    endtask

    task automatic test_random_stall();
        clear_logs();
        for (int c = 0; c < 4; c++) begin
            int npk = $urandom_range(1, 3);
            for (int p = 0; p < npk; p++) add_packet(c, $urandom_range(1, 24));
        end
        add_packet($urandom_range(0, 3), 270);
        model_build();
        rnd_ready = 1'b1;
        drain(20000, "random_stall");
        rnd_ready = 1'b0;
        checks++;
        if (trunc_seen != trunc_exp) begin
            errors++;
            $display("FAIL random_trunc_count: got %0d required %0d", trunc_seen, trunc_exp);
        end
    endtask

    task automatic test_bubbles();
        clear_logs();
        for (int p = 0; p < 6; p++) add_packet(3, $urandom_range(1, 20));
        model_build();
        bubble_en = 1'b1;
        rnd_ready = 1'b1;
        drain(5000, "bubbles");
        bubble_en = 1'b0;
        rnd_ready = 1'b0;
    endtask

    task automatic test_arb_en();
        bit ok;
        apply_reset();
        add_packet(0, 2);
        add_packet(1, 12);
        add_packet(2, 3);
        model_build();
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            step();
            ok = (hdr_log.size() >= 2);
        end
        arb_en_cmd = 1'b0;
        for (int i = 0; i < 200 && ok && !(len_log.size() >= 2 && !s_busy); i++) step();
        repeat (20) step();
        checks++;
        if (!ok || hdr_log.size() != 2 || len_log.size() != 2 || s_busy !== 1'b0) begin
            errors++;
            $display("FAIL arb_en_hold: got %0d headers %0d bursts busy=%0b required 2 2 0",
                     hdr_log.size(), len_log.size(), s_busy);
        end
        checks++;
        if (drv_q[2].size() != 3) begin
            errors++;
            $display("FAIL arb_en_ch2_untouched: got %0d words left required 3", drv_q[2].size());
        end
        arb_en_cmd = 1'b1;
        drain(200, "arb_en");
        checks++;
        if (hdr_log.size() != 3 || hdr_log[hdr_log.size() - 1] !== 32'hA500_0002) begin
            errors++;
            $display("FAIL arb_en_next_grant: got %0d headers last=%h required 3 A5000002", hdr_log.size(),
                     (hdr_log.size() > 0) ? hdr_log[hdr_log.size() - 1] : 32'h0);
        end
    endtask

    task automatic test_reset_mid_burst();
        bit ok;
        apply_reset();
        add_packet(0, 260);
        model_build();
        ok = 1'b0;
        for (int i = 0; i < 1000 && !ok; i++) begin
            step();
            ok = (hdr_log.size() >= 2) && (cur_len >= 2);
        end
        checks++;
        if (!ok || hdr_log[hdr_log.size() - 1] !== 32'hA501_0000) begin
            errors++;
            $display("FAIL midreset_setup: got %0d headers required continuation header A5010000", hdr_log.size());
        end
        @(negedge clk_in);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_sop, out_eop, trunc_pulse, busy, grant_ch, req_ready, out_data} !== 42'd0) begin
            errors++;
            $display("FAIL midreset_values: got v=%0b sop=%0b eop=%0b tr=%0b busy=%0b g=%0d rdy=%b d=%h required all 0",
                     out_valid, out_sop, out_eop, trunc_pulse, busy, grant_ch, req_ready, out_data);
        end
        clear_tb_state();
        req_valid = 4'b0;
        repeat (2) @(negedge clk_in);
        rst_n = 1'b1;
        add_packet(1, 2);
        add_packet(0, 1);
        model_build();
        drain(100, "after_reset");
        checks++;
        if (hdr_log.size() != 2 || hdr_log[0] !== 32'hA500_0000 || hdr_log[1] !== 32'hA500_0001) begin
            errors++;
            $display("FAIL midreset_restart: got %0d headers first=%h required 2 A5000000 A5000001", hdr_log.size(),
                     (hdr_log.size() > 0) ? hdr_log[0] : 32'h0);
        end
    endtask

    initial begin
        gap_chk    = 1'b0;
        rnd_ready  = 1'b0;
        bubble_en  = 1'b0;
        arb_en_cmd = 1'b1;
        clear_tb_state();
        test_reset();
        test_single();
        test_round_robin();
        test_truncation();
        test_random_stall();
        test_bubbles();
        test_arb_en();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule
